// File: rtl/hex_display_pkg.sv
// Shared types and constants for the hex display controller: FSM states and
// active-low 7-segment patterns (bit order g..a).
package hex_display_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShow,
    StScroll
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/hex_seg7.sv
// Combinational nibble-to-7-segment encoder (active-low, g..a), with blank override.
module hex_seg7
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = blank_i ? SEG_BLANK : SEG_LUT[nibble_i];
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex display controller: static/scroll modes, leading-zero blanking,
// two-stage registered output. Optional blink is built with HEX_DISPLAY_BLINK_EN.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned TICK_DIV   = 25000000
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic                    load_ready,
  input  logic                    scroll_en,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam int unsigned OffW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned ValW = 4 * NUM_DIGITS;
  localparam int unsigned SegW = 7 * NUM_DIGITS;

  state_e                state_q, state_d;
  logic [ValW-1:0]       value_q, value_d;
  logic                  ready_q, ready_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [OffW-1:0]       offset_q, offset_d;
  logic [ValW-1:0]       nib_q, nib_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic [SegW-1:0]       hex_out_q, hex_out_d;
  logic [SegW-1:0]       seg_w;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  accept;
  logic                  tick;
  logic                  hide;

  assign accept     = load_valid & ready_q;
  assign tick       = (cnt_q == CntW'(TICK_DIV - 1));
  assign load_ready = ready_q;
  assign hex_out    = hex_out_q;

`ifdef HEX_DISPLAY_BLINK_EN
  logic phase_q, phase_d;

  // phase_q = 1 means the hidden half of the blink period.
  assign phase_d = tick ? ~phase_q : phase_q;
  assign hide    = blink_en & phase_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end
`else
  logic unused_blink_en;

  assign unused_blink_en = blink_en;
  assign hide            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = scroll_en ? StScroll : StShow;
      StShow:   if (scroll_en) state_d = StScroll;
      StScroll: if (!scroll_en) state_d = StShow;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    value_d = accept ? load_value : value_q;
    ready_d = ~accept;
    cnt_d   = tick ? '0 : cnt_q + CntW'(1);
    // Offset only advances while staying in scroll mode with no new value.
    if (accept || (state_q != StScroll) || (state_d != StScroll)) begin
      offset_d = '0;
    end else if (tick) begin
      offset_d = (offset_q == OffW'(NUM_DIGITS - 1)) ? '0 : offset_q + OffW'(1);
    end else begin
      offset_d = offset_q;
    end
  end

  always_comb begin
    logic run;
    run     = 1'b1;
    lz_mask = '0;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      run        = run & (value_q[4*i +: 4] == 4'h0);
      lz_mask[i] = run;
    end
  end

  always_comb begin
    int unsigned idx;
    nib_d   = value_q;
    blank_d = '0;
    unique case (state_q)
      StIdle:   blank_d = '1;
      StShow:   blank_d = blank_lz ? lz_mask : '0;
      StScroll: begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          idx = i + 32'(offset_q);
          if (idx >= NUM_DIGITS) idx = idx - NUM_DIGITS;
          nib_d[4*i +: 4] = value_q[4*idx +: 4];
        end
      end
      default:  blank_d = '1;
    endcase
    if (hide) blank_d = '1;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    hex_seg7 u_seg (
      .nibble_i(nib_q[4*g +: 4]),
      .blank_i (blank_q[g]),
      .seg_o   (seg_w[7*g +: 7])
    );
  end

  assign hex_out_d = seg_w;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= StIdle;
      value_q   <= '0;
      ready_q   <= 1'b0;
      cnt_q     <= '0;
      offset_q  <= '0;
      nib_q     <= '0;
      blank_q   <= '1;
      hex_out_q <= '1;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      ready_q   <= ready_d;
      cnt_q     <= cnt_d;
      offset_q  <= offset_d;
      nib_q     <= nib_d;
      blank_q   <= blank_d;
      hex_out_q <= hex_out_d;
    end
  end

endmodule
